// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared types, key map and constants for the note scheduler
package note_pkg;

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_e;

  localparam logic [7:0] KEY_LANE0 = 8'h04;
  localparam logic [7:0] KEY_LANE1 = 8'h16;
  localparam logic [7:0] KEY_LANE2 = 8'h07;
  localparam logic [7:0] KEY_LANE3 = 8'h09;

  localparam int TILE_S   = 75;
  localparam int Y_BOTTOM = 479;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Returns {valid, lane}; valid is 0 for any unmapped scancode.
  function automatic logic [2:0] key_lane(input logic [7:0] code);
    logic [2:0] res;
    case (code)
      KEY_LANE0: res = 3'b100;
      KEY_LANE1: res = 3'b101;
      KEY_LANE2: res = 3'b110;
      KEY_LANE3: res = 3'b111;
      default:   res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/note_scheduler_lfsr8.sv
// rtl/note_scheduler_lfsr8.sv - free-running 8-bit Fibonacci LFSR, taps 8,6,5,4
module lfsr8
  import note_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset,
  output logic [7:0] out
);

  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - game controller: spawns tiles, judges presses, scores, ends on a miss
module note_scheduler
  import note_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int SPAWN_GAP      = 40,
  parameter int HIT_Y_MIN      = 300,
  parameter int HIT_Y_MAX      = 403,
  parameter int HITS_PER_LEVEL = 16
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    start,
  input  logic [7:0]              keycode,
  input  logic [10*NUM_LANES-1:0] tile_y,
  output logic [NUM_LANES-1:0]    new_note,
  output logic [NUM_LANES-1:0]    kill,
  output logic [3:0]              speed,
  output logic [15:0]             score,
  output logic [NUM_LANES-1:0]    lane_active,
  output logic                    game_over
);

  localparam logic [7:0] GAP_LAST = 8'(SPAWN_GAP - 1);
  localparam logic [9:0] Y_MIN    = 10'(HIT_Y_MIN);
  localparam logic [9:0] Y_MAX    = 10'(HIT_Y_MAX);

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [7:0]             prev_key_q;
  logic [NUM_LANES-1:0]   new_note_q, new_note_d, kill_q, kill_d;
  logic [NUM_LANES-1:0]   active_q, active_d;
  logic [3:0]             speed_q, speed_d;
  logic [15:0]            score_q, score_d, score_inc;
  logic                   over_q, over_d;

  logic [7:0]             lfsr_val;
  logic                   lfsr_unused;
  logic [2:0]             key_info;
  logic                   press, in_window, hit, miss;
  logic [1:0]             press_lane, spawn_lane, scan_idx;
  logic [9:0]             press_y;
  logic                   spawn_found;
  logic [NUM_LANES-1:0]   escape;

  lfsr8 u_lfsr (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .out       (lfsr_val)
  );

  assign lfsr_unused = ^lfsr_val[7:2];

  assign key_info   = key_lane(keycode);
  assign press      = key_info[2] && (keycode != prev_key_q);
  assign press_lane = key_info[1:0];
  assign press_y    = tile_y[10*int'(press_lane) +: 10];
  assign in_window  = (press_y >= Y_MIN) && (press_y <= Y_MAX);
  assign hit        = press && active_q[press_lane] && in_window;
  assign miss       = press && !hit;
  assign score_inc  = score_q + 16'd1;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      escape[i] = active_q[i] &&
                  (({1'b0, tile_y[10*i +: 10]} + 11'(TILE_S)) >= 11'(Y_BOTTOM));
    end
  end

  // Lanes killed this frame are still set in active_q, so they read as busy here.
  always_comb begin
    spawn_found = 1'b0;
    spawn_lane  = '0;
    scan_idx    = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      scan_idx = lfsr_val[1:0] + 2'(i);
      if (!active_q[scan_idx]) begin
        spawn_found = 1'b1;
        spawn_lane  = scan_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    new_note_d = '0;
    kill_d     = '0;
    speed_d    = speed_q;
    score_d    = score_q;
    active_d   = active_q;
    over_d     = over_q;
    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          score_d  = '0;
          speed_d  = '0;
          active_d = '0;
          kill_d   = '1;
          over_d   = 1'b0;
        end
      end
      RUN: begin
        if (miss || (|escape)) begin
          state_d  = OVER;
          over_d   = 1'b1;
          kill_d   = '1;
          active_d = '0;
        end else begin
          if (hit) begin
            kill_d[press_lane]   = 1'b1;
            active_d[press_lane] = 1'b0;
            if (score_q != 16'hFFFF) begin
              score_d = score_inc;
              if ((score_inc % 16'(HITS_PER_LEVEL)) == 16'd0 && speed_q != 4'hF)
                speed_d = speed_q + 4'd1;
            end
          end
          // With every lane busy the counter parks on its last value until one frees.
          if (cnt_q == GAP_LAST) begin
            if (spawn_found) begin
              new_note_d[spawn_lane] = 1'b1;
              active_d[spawn_lane]   = 1'b1;
              cnt_d                  = '0;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prev_key_q <= '0;
      new_note_q <= '0;
      kill_q     <= '0;
      active_q   <= '0;
      speed_q    <= '0;
      score_q    <= '0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_key_q <= keycode;
      new_note_q <= new_note_d;
      kill_q     <= kill_d;
      active_q   <= active_d;
      speed_q    <= speed_d;
      score_q    <= score_d;
      over_q     <= over_d;
    end
  end

  assign new_note    = new_note_q;
  assign kill        = kill_q;
  assign speed       = speed_q;
  assign score       = score_q;
  assign lane_active = active_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_note_scheduler.sv
// tb/tb_note_scheduler.sv - directed self-checking bench for note_scheduler
module tb_note_scheduler;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [7:0]  keycode;
  logic [39:0] tile_y;
  logic [3:0]  new_note, kill, lane_active;
  logic [3:0]  speed;
  logic [15:0] score;
  logic        game_over;

  int total = 0;
  int bad   = 0;
  int spawned_lane;
  int exp_score;
  logic [7:0] keys [4];

  note_scheduler dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .start       (start),
    .keycode     (keycode),
    .tile_y      (tile_y),
    .new_note    (new_note),
    .kill        (kill),
    .speed       (speed),
    .score       (score),
    .lane_active (lane_active),
    .game_over   (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic wait_spawn(output int lane);
    bit seen;
    seen = 0;
    lane = 0;
    for (int t = 0; t < 60 && !seen; t++) begin
      tick();
      if (new_note != 4'b0000) begin
        seen = 1;
        for (int i = 0; i < 4; i++) if (new_note[i]) lane = i;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL spawn_timeout: no new_note within 60 frames, required one");
    end
  endtask

  task automatic do_hit(input int lane, input logic [9:0] y);
    tile_y[lane*10 +: 10] = y;
    keycode = keys[lane];
    tick();
    keycode = 8'h00;
    tile_y[lane*10 +: 10] = 10'd0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_score = 0;
  endtask

  task automatic test_reset();
    total += 6;
    if (new_note !== 4'b0)    begin bad++; $display("FAIL reset_new_note: got %b want 0000", new_note); end
    if (kill !== 4'b0)        begin bad++; $display("FAIL reset_kill: got %b want 0000", kill); end
    if (speed !== 4'd0)       begin bad++; $display("FAIL reset_speed: got %0d want 0", speed); end
    if (score !== 16'd0)      begin bad++; $display("FAIL reset_score: got %0d want 0", score); end
    if (lane_active !== 4'b0) begin bad++; $display("FAIL reset_lane_active: got %b want 0000", lane_active); end
    if (game_over !== 1'b0)   begin bad++; $display("FAIL reset_game_over: got %b want 0", game_over); end
  endtask

  task automatic test_start_spawn();
    bit early;
    do_start();
    total += 2;
    if (kill !== 4'b1111)   begin bad++; $display("FAIL start_kill: got %b want 1111", kill); end
    if (game_over !== 1'b0) begin bad++; $display("FAIL start_game_over: got %b want 0", game_over); end
    early = 0;
    for (int t = 1; t < 40; t++) begin
      tick();
      if (new_note !== 4'b0) early = 1;
    end
    total++;
    if (early) begin bad++; $display("FAIL spawn_early: new_note rose before frame 40, required 0"); end
    tick();
    total += 2;
    if ($countones(new_note) != 1) begin bad++; $display("FAIL spawn_onehot: got %b want one bit", new_note); end
    if (lane_active !== new_note)  begin bad++; $display("FAIL spawn_active: got %b want %b", lane_active, new_note); end
    for (int i = 0; i < 4; i++) if (new_note[i]) spawned_lane = i;
    tick();
    total++;
    if (new_note !== 4'b0) begin bad++; $display("FAIL spawn_pulse: got %b want 0000", new_note); end
  endtask

  task automatic test_hit();
    bit extra;
    int lane;
    lane = spawned_lane;
    tile_y[lane*10 +: 10] = 10'd350;
    keycode = keys[lane];
    tick();
    exp_score = 1;
    total += 3;
    if (kill !== 4'(1 << lane))        begin bad++; $display("FAIL hit_kill: got %b want %b", kill, 4'(1 << lane)); end
    if (score !== 16'(exp_score))      begin bad++; $display("FAIL hit_score: got %0d want %0d", score, exp_score); end
    if (lane_active[lane] !== 1'b0)    begin bad++; $display("FAIL hit_clear: got %b want 0", lane_active[lane]); end
    extra = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (kill !== 4'b0 || game_over !== 1'b0) extra = 1;
    end
    total++;
    if (extra) begin bad++; $display("FAIL held_key: kill or game_over rose while key held, required none"); end
    keycode = 8'h00;
    tile_y[lane*10 +: 10] = 10'd0;
  endtask

  task automatic test_speed();
    int lane;
    while (exp_score < 256) begin
      wait_spawn(lane);
      do_hit(lane, 10'd320);
      exp_score++;
      if (exp_score == 16) begin
        total += 2;
        if (score !== 16'd16) begin bad++; $display("FAIL level1_score: got %0d want 16", score); end
        if (speed !== 4'd1)   begin bad++; $display("FAIL level1_speed: got %0d want 1", speed); end
      end
      if (exp_score == 32) begin
        total++;
        if (speed !== 4'd2) begin bad++; $display("FAIL level2_speed: got %0d want 2", speed); end
      end
      if (exp_score == 240) begin
        total++;
        if (speed !== 4'd15) begin bad++; $display("FAIL level15_speed: got %0d want 15", speed); end
      end
    end
    total += 2;
    if (score !== 16'd256) begin bad++; $display("FAIL sat_score: got %0d want 256", score); end
    if (speed !== 4'd15)   begin bad++; $display("FAIL sat_speed: got %0d want 15", speed); end
  endtask

  task automatic test_miss();
    int lane;
    wait_spawn(lane);
    tile_y[lane*10 +: 10] = 10'd200;
    keycode = keys[lane];
    tick();
    total += 4;
    if (game_over !== 1'b1)     begin bad++; $display("FAIL miss_over: got %b want 1", game_over); end
    if (kill !== 4'b1111)       begin bad++; $display("FAIL miss_kill: got %b want 1111", kill); end
    if (score !== 16'd256)      begin bad++; $display("FAIL miss_score: got %0d want 256", score); end
    if (lane_active !== 4'b0)   begin bad++; $display("FAIL miss_active: got %b want 0000", lane_active); end
    keycode = 8'h00;
    tile_y[lane*10 +: 10] = 10'd0;
    tick();
    total += 2;
    if (kill !== 4'b0)      begin bad++; $display("FAIL over_kill_pulse: got %b want 0000", kill); end
    if (game_over !== 1'b1) begin bad++; $display("FAIL over_hold: got %b want 1", game_over); end
  endtask

  task automatic test_escape();
    int lane;
    do_start();
    total += 3;
    if (game_over !== 1'b0) begin bad++; $display("FAIL restart_over: got %b want 0", game_over); end
    if (score !== 16'd0)    begin bad++; $display("FAIL restart_score: got %0d want 0", score); end
    if (speed !== 4'd0)     begin bad++; $display("FAIL restart_speed: got %0d want 0", speed); end
    wait_spawn(lane);
    do_hit(lane, 10'd403);
    total += 3;
    if (game_over !== 1'b0)     begin bad++; $display("FAIL edge_hit_over: got %b want 0", game_over); end
    if (kill !== 4'(1 << lane)) begin bad++; $display("FAIL edge_hit_kill: got %b want %b", kill, 4'(1 << lane)); end
    if (score !== 16'd1)        begin bad++; $display("FAIL edge_hit_score: got %0d want 1", score); end
    wait_spawn(lane);
    tile_y[lane*10 +: 10] = 10'd403;
    tick();
    total++;
    if (game_over !== 1'b0) begin bad++; $display("FAIL y403_over: got %b want 0", game_over); end
    tile_y[lane*10 +: 10] = 10'd404;
    tick();
    total += 2;
    if (game_over !== 1'b1) begin bad++; $display("FAIL escape_over: got %b want 1", game_over); end
    if (kill !== 4'b1111)   begin bad++; $display("FAIL escape_kill: got %b want 1111", kill); end
    tile_y[lane*10 +: 10] = 10'd0;
  endtask

  task automatic test_back_to_back();
    int lane;
    bit spawned;
    do_start();
    for (int n = 0; n < 4; n++) wait_spawn(lane);
    total++;
    if (lane_active !== 4'b1111) begin bad++; $display("FAIL full_active: got %b want 1111", lane_active); end
    spawned = 0;
    for (int t = 0; t < 45; t++) begin
      tick();
      if (new_note !== 4'b0) spawned = 1;
    end
    total++;
    if (spawned) begin bad++; $display("FAIL full_spawn: new_note rose with all lanes busy, required none"); end
    tile_y[39:30] = 10'd350;
    keycode = 8'h09;
    tick();
    total += 2;
    if (kill !== 4'b1000)     begin bad++; $display("FAIL free3_kill: got %b want 1000", kill); end
    if (new_note !== 4'b0000) begin bad++; $display("FAIL free3_same_frame: got %b want 0000", new_note); end
    keycode = 8'h00;
    tile_y[39:30] = 10'd0;
    tick();
    total += 2;
    if (new_note !== 4'b1000)    begin bad++; $display("FAIL respawn3: got %b want 1000", new_note); end
    if (lane_active !== 4'b1111) begin bad++; $display("FAIL respawn3_active: got %b want 1111", lane_active); end
  endtask

  task automatic test_async_reset();
    #2;
    Reset = 1'b1;
    #1;
    total += 4;
    if (new_note !== 4'b0)    begin bad++; $display("FAIL areset_new_note: got %b want 0000", new_note); end
    if (lane_active !== 4'b0) begin bad++; $display("FAIL areset_active: got %b want 0000", lane_active); end
    if (score !== 16'd0)      begin bad++; $display("FAIL areset_score: got %0d want 0", score); end
    if (game_over !== 1'b0)   begin bad++; $display("FAIL areset_over: got %b want 0", game_over); end
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    keys[0] = 8'h04;
    keys[1] = 8'h16;
    keys[2] = 8'h07;
    keys[3] = 8'h09;
    Reset   = 1'b1;
    start   = 1'b0;
    keycode = 8'h00;
    tile_y  = '0;
    spawned_lane = 0;
    exp_score = 0;
    tick();
    tick();
    test_reset();
    Reset = 1'b0;
    tick();
    test_reset();
    test_start_spawn();
    test_hit();
    test_speed();
    test_miss();
    test_escape();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
